// File: rtl/multdiv_sequencer_pkg.sv
// rtl/multdiv_sequencer_pkg.sv - shared constants and FSM state encoding for the multdiv sequencer
package multdiv_sequencer_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] MUL_EXC     = 32'd4;
    localparam logic [31:0] DIV_EXC     = 32'd5;

    localparam int DEFAULT_TIMEOUT_CYCLES = 40;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_WB    = 2'd3;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - start/operand/result handshake between sequencer and multdiv unit
interface multdiv_sequencer_if;

    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;

    modport master (
        output ctrl_MULT, ctrl_DIV, md_a, md_b,
        input  md_result, md_exception, md_ready
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, md_a, md_b,
        output md_result, md_exception, md_ready
    );

endinterface

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - saturating wait-cycle counter with timeout compare
module md_watchdog
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic expired
);

    logic [5:0] count;

    // Held at zero outside WAIT, so every entry into WAIT starts from a clean count.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            count <= '0;
        end else if (count != 6'h3f) begin
            count <= count + 6'd1;
        end
    end

    assign expired = run && (count >= 6'(TIMEOUT_CYCLES));

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - stalls decode while a mul/div runs on the multdiv unit, then writes back
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                insn_valid,
    input  logic [4:0]          opcode,
    input  logic [4:0]          alu_op,
    input  logic [4:0]          rd,
    input  logic [31:0]         operand_a,
    input  logic [31:0]         operand_b,
    multdiv_sequencer_if.master md,
    output logic                stall,
    output logic                wb_en,
    output logic [4:0]          wb_reg,
    output logic [31:0]         wb_data,
    output logic                timeout
);

    state_t      state;
    logic        is_div;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        detect;
    logic        expired;

    assign detect = !reset && insn_valid && (opcode == OP_RTYPE) &&
                    ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

    md_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .run     (state == S_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            is_div   <= 1'b0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (detect) begin
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        rd_q   <= rd;
                        is_div <= (alu_op == ALU_DIV);
                        state  <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    // A result arriving on the expiry cycle still counts.
                    if (md.md_ready) begin
                        result_q <= md.md_result;
                        exc_q    <= md.md_exception;
                        state    <= S_WB;
                    end else if (expired) begin
                        state <= S_IDLE;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign md.ctrl_MULT = (state == S_START) && !is_div;
    assign md.ctrl_DIV  = (state == S_START) && is_div;
    assign md.md_a      = a_q;
    assign md.md_b      = b_q;

    assign stall   = ((state == S_IDLE) && detect) || (state == S_START) || (state == S_WAIT);
    assign timeout = (state == S_WAIT) && !md.md_ready && expired;

    always_comb begin
        wb_en   = 1'b0;
        wb_reg  = '0;
        wb_data = '0;
        if (state == S_WB) begin
            if (exc_q) begin
                wb_en   = 1'b1;
                wb_reg  = RSTATUS_REG;
                wb_data = is_div ? DIV_EXC : MUL_EXC;
            end else begin
                wb_en   = (rd_q != 5'd0);
                wb_reg  = rd_q;
                wb_data = result_q;
            end
        end
    end

endmodule
